// File: rtl/tdc_meas_if.sv
// tdc_meas_if: control/result bundle between the pin-side sequencer driver
// and tdc_meas_ctrl, plus the delay-line launch/code pair.
//   master: drives ena, cmd_start, avg_sel, tdc_code; observes the rest
//   slave : the controller side (tdc_meas_ctrl)
interface tdc_meas_if #(
    parameter int N_DELAY = 32
);
    logic               ena;
    logic               cmd_start;
    logic [1:0]         avg_sel;
    logic [N_DELAY-1:0] tdc_code;
    logic               tdc_start;
    logic               busy;
    logic               done;
    logic [15:0]        result_sum;
    logic [7:0]         result_avg;
    logic               sat;
    logic               bubble;

    modport master (
        output ena, cmd_start, avg_sel, tdc_code,
        input  tdc_start, busy, done, result_sum, result_avg, sat, bubble
    );

    modport slave (
        input  ena, cmd_start, avg_sel, tdc_code,
        output tdc_start, busy, done, result_sum, result_avg, sat, bubble
    );
endinterface

// File: rtl/tdc_meas_ctrl.sv
// tdc_meas_ctrl: measurement sequencer for the tapped-delay-line TDC.
// Launches the delay-line start edge, waits SETTLE cycles, captures the
// thermometer code, waits SETTLE cycles with the start released, and repeats
// 2^avg_sel times. Reports sum, averaged count, saturation and bubble flags.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus (slave) : ena, cmd_start, avg_sel, tdc_code in;
//                 tdc_start, busy, done, result_sum, result_avg, sat, bubble out
module tdc_meas_ctrl #(
    parameter int N_DELAY = 32,
    parameter int SETTLE  = 2
) (
    input logic       clk,
    input logic       rst_n,
    tdc_meas_if.slave bus
);
    localparam int ACC_W = $clog2(8 * N_DELAY + 1);
    localparam int CNT_W = $clog2(N_DELAY + 1);
    localparam int TMR_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_SETTLE, S_CAPTURE, S_RECOVER, S_DONE
    } state_t;

    state_t             state, state_n;
    logic               tdc_start_n;
    logic [TMR_W-1:0]   tmr;
    logic [3:0]         smp_cnt;
    logic [1:0]         avg_sel_q;
    logic [ACC_W-1:0]   acc;
    logic               sat_acc, bub_acc;

    // Per-sample decode of the thermometer code
    logic [CNT_W-1:0]   smp_count;
    logic               smp_bub, smp_sat, seen_zero;

    always_comb begin
        smp_count = '0;
        smp_bub   = 1'b0;
        seen_zero = 1'b0;
        for (int i = 0; i < N_DELAY; i++) begin
            if (!bus.tdc_code[i])
                seen_zero = 1'b1;
            else if (seen_zero)
                smp_bub = 1'b1;   // stray 1 above the first 0
            else
                smp_count = smp_count + CNT_W'(1);
        end
        smp_sat = (smp_count == CNT_W'(N_DELAY));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            bus.tdc_start <= 1'b0;
        end else begin
            state         <= state_n;
            bus.tdc_start <= tdc_start_n;
        end
    end

    // Next state; tdc_start is registered off the next state so it is high
    // exactly while the FSM sits in LAUNCH/SETTLE/CAPTURE.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (bus.cmd_start) state_n = S_LAUNCH;
            S_LAUNCH:  state_n = S_SETTLE;
            S_SETTLE:  if (tmr == '0) state_n = S_CAPTURE;
            S_CAPTURE: state_n = S_RECOVER;
            S_RECOVER: if (tmr == '0)
                           state_n = (smp_cnt == (4'd1 << avg_sel_q)) ? S_DONE : S_LAUNCH;
            S_DONE:    state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
        if (!bus.ena) state_n = S_IDLE;
        tdc_start_n = (state_n == S_LAUNCH) || (state_n == S_SETTLE) ||
                      (state_n == S_CAPTURE);
    end

    assign bus.busy = (state != S_IDLE);
    assign bus.done = (state == S_DONE);

    // Datapath: timer, accumulator, sticky flags, result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr            <= '0;
            smp_cnt        <= '0;
            avg_sel_q      <= '0;
            acc            <= '0;
            sat_acc        <= 1'b0;
            bub_acc        <= 1'b0;
            bus.result_sum <= '0;
            bus.result_avg <= '0;
            bus.sat        <= 1'b0;
            bus.bubble     <= 1'b0;
        end else begin
            // LAUNCH always precedes SETTLE and CAPTURE precedes RECOVER, so
            // preloading there gives SETTLE cycles in each wait state.
            if (state == S_LAUNCH || state == S_CAPTURE)
                tmr <= TMR_W'(SETTLE - 1);
            else if (tmr != '0)
                tmr <= tmr - TMR_W'(1);

            if (state == S_IDLE && state_n == S_LAUNCH) begin
                avg_sel_q <= bus.avg_sel;
                acc       <= '0;
                smp_cnt   <= '0;
                sat_acc   <= 1'b0;
                bub_acc   <= 1'b0;
            end else if (state == S_CAPTURE && state_n == S_RECOVER) begin
                acc     <= acc + ACC_W'(smp_count);
                smp_cnt <= smp_cnt + 4'd1;
                sat_acc <= sat_acc | smp_sat;
                bub_acc <= bub_acc | smp_bub;
            end

            // Load on entry to DONE so results are valid in the done cycle
            if (state_n == S_DONE) begin
                bus.result_sum <= 16'(acc);
                bus.result_avg <= 8'(acc >> avg_sel_q);
                bus.sat        <= sat_acc;
                bus.bubble     <= bub_acc;
            end
        end
    end
endmodule

// File: tb/tb_tdc_meas_ctrl.sv
module tb_tdc_meas_ctrl;
    localparam int N_DELAY = 32;
    localparam int SETTLE  = 2;
    localparam int P       = 2 * SETTLE + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tdc_meas_if #(.N_DELAY(N_DELAY)) bus();

    tdc_meas_ctrl #(.N_DELAY(N_DELAY), .SETTLE(SETTLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] codes [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input int sum, input int avg, input bit s, input bit b);
        chk({tag, ".sum"}, 32'(bus.result_sum), 32'(sum));
        chk({tag, ".avg"}, 32'(bus.result_avg), 32'(avg));
        chk({tag, ".sat"}, 32'(bus.sat), 32'(s));
        chk({tag, ".bub"}, 32'(bus.bubble), 32'(b));
    endtask

    // Starts a measurement whose start is sampled on the next posedge (edge 0).
    // Samples at the negedge after each edge e; sample k's code is applied
    // after edge k*P so it is stable at its capture edge SETTLE+2+k*P.
    task automatic run(input logic [1:0] sel, input bit hold,
                       output int de, output int np, output int bw);
        int w;
        logic prev;
        de = -1; np = 0; bw = 0; w = 0; prev = 1'b0;
        bus.avg_sel   = sel;
        bus.tdc_code  = codes[0];
        bus.cmd_start = 1'b1;
        for (int e = 0; e < 120; e++) begin
            @(negedge clk);
            if (e == 0 && !hold) bus.cmd_start = 1'b0;
            if (hold && e == 3) bus.avg_sel = 2'd3;
            if (e % P == 0 && e / P < 8) bus.tdc_code = codes[e / P];
            if (bus.tdc_start) begin
                if (!prev) np++;
                w++;
            end else begin
                if (prev && w != SETTLE + 2) bw++;
                w = 0;
            end
            prev = bus.tdc_start;
            if (bus.done) begin
                de = e;
                break;
            end
        end
    endtask

    initial begin
        int de, np, bw;
        bus.ena = 1'b0; bus.cmd_start = 1'b0; bus.avg_sel = 2'd0; bus.tdc_code = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst.tdc_start", 32'(bus.tdc_start), 32'd0);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk_res("rst", 0, 0, 1'b0, 1'b0);
        rst_n = 1'b1; bus.ena = 1'b1;
        @(negedge clk);

        // Single sample, code 0xFF -> 8
        codes[0] = 32'h0000_00FF;
        run(2'd0, 1'b0, de, np, bw);
        chk("t1.done_edge", 32'(de), 32'd6);
        chk("t1.pulses", 32'(np), 32'd1);
        chk_res("t1", 8, 8, 1'b0, 1'b0);
        @(negedge clk);
        chk("t1.done_clr", 32'(bus.done), 32'd0);
        chk("t1.busy_clr", 32'(bus.busy), 32'd0);

        // Four samples: 4+5+6+7 = 22, avg 5
        codes[0] = 32'h0F; codes[1] = 32'h1F; codes[2] = 32'h3F; codes[3] = 32'h7F;
        run(2'd2, 1'b0, de, np, bw);
        chk("t2.done_edge", 32'(de), 32'd24);
        chk("t2.pulses", 32'(np), 32'd4);
        chk("t2.widths", 32'(bw), 32'd0);
        chk_res("t2", 22, 5, 1'b0, 1'b0);
        @(negedge clk);

        // Saturated code
        codes[0] = 32'hFFFF_FFFF;
        run(2'd0, 1'b0, de, np, bw);
        chk("t3.done_edge", 32'(de), 32'd6);
        chk_res("t3", 32, 32, 1'b1, 1'b0);
        @(negedge clk);

        // Bubble: 0xF7 counts 3; sat from previous run must clear
        codes[0] = 32'h0000_00F7;
        run(2'd0, 1'b0, de, np, bw);
        chk_res("t4", 3, 3, 1'b0, 1'b1);
        @(negedge clk);

        // Sticky sat across samples: 32 + 1 = 33, avg 16
        codes[0] = 32'hFFFF_FFFF; codes[1] = 32'h1;
        run(2'd1, 1'b0, de, np, bw);
        chk("t5.done_edge", 32'(de), 32'd12);
        chk_res("t5", 33, 16, 1'b1, 1'b0);
        @(negedge clk);

        // Eight saturated samples: 256, avg 32
        for (int k = 0; k < 8; k++) codes[k] = 32'hFFFF_FFFF;
        run(2'd3, 1'b0, de, np, bw);
        chk("t6.done_edge", 32'(de), 32'd48);
        chk("t6.pulses", 32'(np), 32'd8);
        chk_res("t6", 256, 32, 1'b1, 1'b0);
        @(negedge clk);

        // ena low during SETTLE of sample 2 (after edge P+1)
        bus.avg_sel = 2'd2; bus.tdc_code = 32'h3; bus.cmd_start = 1'b1;
        @(negedge clk);                 // after edge 0
        bus.cmd_start = 1'b0;
        repeat (P + 1) @(negedge clk);  // after edge P+1: in SETTLE
        chk("t7.in_settle", 32'(bus.tdc_start), 32'd1);
        bus.ena = 1'b0;
        @(negedge clk);
        chk("t7.tdc_start", 32'(bus.tdc_start), 32'd0);
        chk("t7.busy", 32'(bus.busy), 32'd0);
        bus.ena = 1'b1;
        de = 0;
        for (int e = 0; e < 40; e++) begin
            @(negedge clk);
            if (bus.done || bus.busy) de++;
        end
        chk("t7.no_done", 32'(de), 32'd0);
        chk_res("t7", 256, 32, 1'b1, 1'b0);

        // cmd_start held high; avg_sel change mid-run ignored (sum 2, avg 1)
        codes[0] = 32'h1; codes[1] = 32'h1;
        run(2'd1, 1'b1, de, np, bw);
        chk("t8.done_edge", 32'(de), 32'd12);
        chk("t8.pulses", 32'(np), 32'd2);
        chk_res("t8", 2, 1, 1'b0, 1'b0);
        @(negedge clk);                 // after edge n*P+1: IDLE
        chk("t8.idle_gap", 32'(bus.busy), 32'd0);
        @(negedge clk);                 // after edge n*P+2: restarted
        chk("t8.restart_busy", 32'(bus.busy), 32'd1);
        chk("t8.restart_start", 32'(bus.tdc_start), 32'd1);
        bus.cmd_start = 1'b0; bus.ena = 1'b0;
        @(negedge clk);
        bus.ena = 1'b1;
        chk("t8.abort", 32'(bus.busy), 32'd0);
        @(negedge clk);

        // Asynchronous reset mid-CAPTURE
        bus.avg_sel = 2'd0; bus.tdc_code = 32'hFF; bus.cmd_start = 1'b1;
        @(negedge clk);                 // after edge 0
        bus.cmd_start = 1'b0;
        repeat (SETTLE + 1) @(negedge clk);  // after edge SETTLE+1: CAPTURE
        rst_n = 1'b0;
        #1;
        chk("t9.tdc_start", 32'(bus.tdc_start), 32'd0);
        chk("t9.busy", 32'(bus.busy), 32'd0);
        chk("t9.done", 32'(bus.done), 32'd0);
        chk_res("t9", 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("t9.idle", 32'(bus.busy), 32'd0);

        // Operation after reset: 0x1F -> 5
        codes[0] = 32'h1F;
        run(2'd0, 1'b0, de, np, bw);
        chk("t10.done_edge", 32'(de), 32'd6);
        chk_res("t10", 5, 5, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tdc_meas_ctrl.md
# tdc_meas_ctrl

Measurement sequencer for the tapped-delay-line TDC. On command, it launches the delay-line start edge and holds it for a programmable settle time. It then captures the thermometer code, converts it to a tap count and repeats the cycle 1/2/4/8 times. It reports the sum and the averaged count together with saturation and bubble flags. It sits between the `ui_in` control pins and the delay-line instance and replaces direct pin-driven start in the top level.

## Interface
- `N_DELAY`, 32: number of delay-line taps, equal to the width of `tdc_code`.
- `SETTLE`, 2: cycles the controller waits after launch, and after release, before capture or relaunch. Must be ≥1.
- `clk` in 1: system clock. All state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `ena` in 1: block enable. When low, the FSM is forced to IDLE.
- `cmd_start` in 1: start request, sampled only in IDLE.
- `avg_sel` in 2: sample count = 2^`avg_sel` (1, 2, 4 or 8). Latched at start.
- `tdc_code` in `N_DELAY`: thermometer code from the delay line. Bit 0 is the first tap.
- `tdc_start` out 1: launch edge to the delay line, registered.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when results update.
- `result_sum` out 16: sum of the tap counts of all samples.
- `result_avg` out 8: `result_sum >> avg_sel_latched` (truncating).
- `sat` out 1: sticky per measurement. Set if any sample has count == `N_DELAY`.
- `bubble` out 1: sticky per measurement. Set if any sample has a 1 above its first 0.

## Operation
- States: IDLE, LAUNCH, SETTLE, CAPTURE, RECOVER, DONE.
- IDLE, with `ena`=1 and `cmd_start`=1:
  - latch `avg_sel`
  - clear the accumulator, sample counter and sticky flags
  - go to LAUNCH
- LAUNCH (1 cycle): go to SETTLE.
- SETTLE (`SETTLE` cycles, down-counter): go to CAPTURE.
- CAPTURE (1 cycle): on the closing edge, add count(`tdc_code`) to the accumulator, update the flags, increment the sample counter, then go to RECOVER.
- RECOVER (`SETTLE` cycles): go to LAUNCH if samples remain, otherwise go to DONE.
- DONE (1 cycle):
  - `done`=1
  - `result_sum`/`result_avg`/`sat`/`bubble` load from the accumulator and flags
  - go to IDLE
- `tdc_start`=1 in LAUNCH, SETTLE and CAPTURE, and 0 elsewhere.
- count(code) = number of consecutive 1s starting at bit 0, range 0..`N_DELAY`. Higher stray 1s are ignored for the count and set `bubble`.
- Accumulator width is clog2(8·`N_DELAY`+1), zero-extended to 16 bits.
- `cmd_start` outside IDLE is ignored, with no queuing.
- `ena` low in any state:
  - next state is IDLE and `tdc_start` drops next cycle
  - no `done` pulse
  - result registers keep their previous values
  - in-progress accumulation is discarded
- `cmd_start` high in the same cycle DONE is exiting is not accepted. It is sampled again in IDLE on the next cycle.

## Timing
- Reset values: state IDLE, `tdc_start`=0, `busy`=0, `done`=0, `result_sum`=0, `result_avg`=0, `sat`=0, `bubble`=0.
- Let edge 0 be the edge that samples `cmd_start` in IDLE. LAUNCH is entered at edge 0.
- Per sample, with n the sample count:
  - `tdc_start` is high for `SETTLE`+2 cycles, then low for `SETTLE` cycles.
  - One sample period P = 2·`SETTLE`+2 cycles.
- `tdc_code` is sampled on edge `SETTLE`+2 + k·P for sample k.
- `done` is high in the cycle following edge n·P, and the results are valid from that same cycle.
- `busy` is high from edge 0 through the DONE cycle.
- The earliest next start is sampled at edge n·P+2.
- Results only change at DONE, so they are stable while `busy`=1.

## Test plan
- Reset with `N_DELAY`=32, `SETTLE`=2, then one start with `avg_sel`=0 and code 0x000000FF → `done` after 6 cycles, `result_sum`=8, `result_avg`=8, `sat`=0, `bubble`=0.
- `avg_sel`=2 with codes 0x0F, 0x1F, 0x3F, 0x7F per sample → `result_sum`=22, `result_avg`=5, `done` at cycle 24, exactly four `tdc_start` pulses each 4 cycles wide.
- Code 0xFFFFFFFF → count 32 and `sat`=1. Code 0x000000F7 → count 3 and `bubble`=1.
- Pulse `ena` low during SETTLE of sample 2 → `tdc_start` low next cycle, `busy`=0, no `done`, previous results unchanged.
- `cmd_start` held high through a measurement → one measurement only. The next starts at edge n·P+2, and new `avg_sel` values applied mid-run have no effect.
- Assert `rst_n` low mid-CAPTURE → all outputs zero immediately, asynchronously, and the FSM is in IDLE after release.
